// File: rtl/tmp101_pkg.sv
// Shared types and sizing for the TMP101 temperature formatter.
package tmp101_pkg;

  localparam int RAW_W      = 12;
  localparam int INT_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int DD_STEPS   = 8;

  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int FRAC_W     = RAW_W - INT_W;
  localparam int STEP_CNT_W = $clog2(DD_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    GOT_MSB,
    CONVERT
  } state_t;

endpackage

// File: rtl/bin8_to_bcd3_iter.sv
// Iterative 8-bit binary to 3-digit BCD converter (double-dabble, one shift per cycle).
// Done is high during the cycle whose closing edge performs the final step;
// Bcd is rewritten on that same edge and otherwise holds the last complete result.
module bin8_to_bcd3_iter
  import tmp101_pkg::*;
(
  input  logic             clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [INT_W-1:0] Bin,
  output logic             Done,
  output logic [BCD_W-1:0] Bcd
);

  localparam int SR_W = BCD_W + INT_W;

  logic [SR_W-1:0]       shift_reg;
  logic [SR_W-1:0]       shift_next;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic                  running;

  // One double-dabble step: adjust every BCD nibble >= 5 by +3, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[INT_W+4*d +: 4] >= 4'd5) begin
        t[INT_W+4*d +: 4] = t[INT_W+4*d +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign shift_next = dd_step(shift_reg);
  assign Done       = running && (step_cnt == STEP_CNT_W'(DD_STEPS - 1));

  // Working shift register: loaded with the binary value, then stepped while running.
  always_ff @(posedge clock) begin
    if (Load) begin
      shift_reg <= {{BCD_W{1'b0}}, Bin};
    end else if (running) begin
      shift_reg <= shift_next;
    end
  end

  // Step counter, run flag and the published BCD result.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      running  <= 1'b0;
      step_cnt <= '0;
      Bcd      <= '0;
    end else if (Load) begin
      running  <= 1'b1;
      step_cnt <= '0;
    end else if (running) begin
      step_cnt <= step_cnt + 1'b1;
      if (Done) begin
        running <= 1'b0;
        Bcd     <= shift_next[SR_W-1:INT_W];
      end
    end
  end

endmodule

// File: rtl/tmp101_temperature_formatter.sv
// Collects the MSB/LSB of a TMP101 read, decodes the 12-bit two's-complement
// reading and publishes sign, BCD integer digits and a truncated tenths digit.
module tmp101_temperature_formatter
  import tmp101_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       FrameStart,
  input  logic       ByteValid,
  input  logic [7:0] ReceivedData,
  output logic       Sign,
  output logic [3:0] Hundreds,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic [3:0] Tenths,
  output logic       TempValid,
  output logic       Busy,
  output logic       ByteDropped
);

  state_t state;
  state_t state_next;

  logic [7:0]              first_byte;
  logic signed [RAW_W-1:0] raw;
  logic [RAW_W-1:0]        mag;
  logic                    pend_sign;
  logic [3:0]              pend_tenths;
  logic                    capture_first;
  logic                    load;
  logic                    drop;
  logic                    conv_done;
  logic [BCD_W-1:0]        bcd;

  // Absolute value in RAW_W bits; the most negative code maps onto itself (128.0).
  function automatic logic [RAW_W-1:0] magnitude(input logic signed [RAW_W-1:0] r);
    logic [RAW_W-1:0] u;
    u = $unsigned(r);
    return u[RAW_W-1] ? (~u + RAW_W'(1)) : u;
  endfunction

  // Tenths digit from a 1/16 fraction: floor(f * 10 / 16), never rounds up.
  function automatic logic [3:0] tenths_of(input logic [FRAC_W-1:0] f);
    logic [7:0] p;
    p = {1'b0, f, 3'b000} + {3'b000, f, 1'b0};
    return p[7:4];
  endfunction

  // The second byte only contributes its top nibble; the low nibble is padding.
  assign raw = (MSB_FIRST != 0) ? {first_byte, ReceivedData[7:4]}
                                : {ReceivedData, first_byte[7:4]};
  assign mag = magnitude(raw);

  bin8_to_bcd3_iter u_bcd (
    .clock (clock),
    .Reset (Reset),
    .Load  (load),
    .Bin   (mag[RAW_W-1:FRAC_W]),
    .Done  (conv_done),
    .Bcd   (bcd)
  );

  assign Hundreds = bcd[11:8];
  assign Tens     = bcd[7:4];
  assign Ones     = bcd[3:0];
  assign Busy     = (state == CONVERT);

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and byte-handling decisions; FrameStart outranks a plain ByteValid.
  always_comb begin
    state_next    = state;
    capture_first = 1'b0;
    load          = 1'b0;
    drop          = 1'b0;
    case (state)
      IDLE: begin
        if (ByteValid) begin
          capture_first = 1'b1;
          state_next    = GOT_MSB;
        end
      end
      GOT_MSB: begin
        if (FrameStart) begin
          if (ByteValid) begin
            capture_first = 1'b1;
            state_next    = GOT_MSB;
          end else begin
            state_next = IDLE;
          end
        end else if (ByteValid) begin
          load       = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (ByteValid) begin
          drop = 1'b1;
        end
        if (conv_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte latch and the sign/tenths parked until the BCD conversion finishes.
  always_ff @(posedge clock) begin
    if (capture_first) begin
      first_byte <= ReceivedData;
    end
    if (load) begin
      pend_sign   <= raw[RAW_W-1];
      pend_tenths <= tenths_of(mag[FRAC_W-1:0]);
    end
  end

  // Published result flags and pulses; all result fields change together.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      Sign        <= 1'b0;
      Tenths      <= 4'd0;
      TempValid   <= 1'b0;
      ByteDropped <= 1'b0;
    end else begin
      TempValid   <= conv_done;
      ByteDropped <= drop;
      if (conv_done) begin
        Sign   <= pend_sign;
        Tenths <= pend_tenths;
      end
    end
  end

endmodule

// File: tb/tb_tmp101_temperature_formatter.sv
// Bench for tmp101_temperature_formatter: directed table, corner sequences, random frames.
module tb_tmp101_temperature_formatter;

  logic       clock = 1'b0;
  logic       Reset;
  logic       FrameStart;
  logic       ByteValid;
  logic [7:0] ReceivedData;
  logic       Sign;
  logic [3:0] Hundreds;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic [3:0] Tenths;
  logic       TempValid;
  logic       Busy;
  logic       ByteDropped;

  int checks   = 0;
  int errors   = 0;
  int last_exp = 0;

  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    int         sgn;
    int         h;
    int         t;
    int         o;
    int         tn;
  } vec_t;

  vec_t vecs[10];

  tmp101_temperature_formatter #(.MSB_FIRST(1)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .FrameStart   (FrameStart),
    .ByteValid    (ByteValid),
    .ReceivedData (ReceivedData),
    .Sign         (Sign),
    .Hundreds     (Hundreds),
    .Tens         (Tens),
    .Ones         (Ones),
    .Tenths       (Tenths),
    .TempValid    (TempValid),
    .Busy         (Busy),
    .ByteDropped  (ByteDropped)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int pack(input int s, input int h, input int t, input int o, input int tn);
    return (s << 16) | (h << 12) | (t << 8) | (o << 4) | tn;
  endfunction

  function automatic int outputs_now();
    return pack(int'(Sign), int'(Hundreds), int'(Tens), int'(Ones), int'(Tenths));
  endfunction

  // Reference: interpret the reading as a signed count of 1/16 degC and print it in decimal.
  function automatic int model(input logic [7:0] msb, input logic [7:0] lsb);
    int r;
    int m;
    int ip;
    r = int'({msb, lsb[7:4]});
    if (r >= 2048) r = r - 4096;
    m  = (r < 0) ? -r : r;
    ip = m / 16;
    return pack((r < 0) ? 1 : 0, ip / 100, (ip / 10) % 10, ip % 10, ((m % 16) * 10) / 16);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!TempValid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Send MSB then LSB, optionally inject a stray byte drop_at cycles after the LSB edge.
  task automatic run_frame(input logic [7:0] msb, input logic [7:0] lsb, input int exp,
                           input int drop_at, input string tag);
    int n;
    int ndrop;
    ByteValid = 1'b1; ReceivedData = msb; tick();
    ByteValid = 1'b0; tick();
    ByteValid = 1'b1; ReceivedData = lsb; tick();
    ByteValid = 1'b0;
    check({tag, " busy"}, int'(Busy), 1);
    n = 0;
    ndrop = 0;
    while (!TempValid && n < 20) begin
      if (n == 3) check({tag, " hold"}, outputs_now(), last_exp);
      if (n == drop_at) begin
        ByteValid = 1'b1;
        ReceivedData = 8'h55;
      end
      tick();
      ByteValid = 1'b0;
      n++;
      if (ByteDropped) ndrop++;
    end
    check({tag, " latency"}, n, 8);
    check({tag, " result"}, outputs_now(), exp);
    check({tag, " busy_end"}, int'(Busy), 0);
    tick();
    if (ByteDropped) ndrop++;
    check({tag, " pulse"}, int'(TempValid), 0);
    check({tag, " drops"}, ndrop, (drop_at >= 0) ? 1 : 0);
    last_exp = exp;
  endtask

  initial begin
    int n;
    int nv;
    int exp;
    int drop_at;
    logic [7:0] m8;
    logic [7:0] l8;

    vecs[0] = '{8'h19, 8'h00, 0, 0, 2, 5, 0};
    vecs[1] = '{8'hE7, 8'h00, 1, 0, 2, 5, 0};
    vecs[2] = '{8'h32, 8'h80, 0, 0, 5, 0, 5};
    vecs[3] = '{8'h80, 8'h00, 1, 1, 2, 8, 0};
    vecs[4] = '{8'hFF, 8'hF0, 1, 0, 0, 0, 0};
    vecs[5] = '{8'h00, 8'hF0, 0, 0, 0, 0, 9};
    vecs[6] = '{8'h7F, 8'hF0, 0, 1, 2, 7, 9};
    vecs[7] = '{8'hFE, 8'h80, 1, 0, 0, 1, 5};
    vecs[8] = '{8'h01, 8'h1F, 0, 0, 0, 1, 0};
    vecs[9] = '{8'h64, 8'h4A, 0, 1, 0, 0, 2};

    Reset = 1'b0; FrameStart = 1'b0; ByteValid = 1'b0; ReceivedData = 8'h00;
    tick();
    tick();
    check("reset outputs", outputs_now(), 0);
    check("reset tempvalid", int'(TempValid), 0);
    check("reset busy", int'(Busy), 0);
    check("reset dropped", int'(ByteDropped), 0);
    Reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].msb, vecs[i].lsb,
                pack(vecs[i].sgn, vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].tn),
                -1, $sformatf("vec%0d", i));
    end

    // FrameStart in GOT_MSB discards the pending MSB.
    ByteValid = 1'b1; ReceivedData = 8'h19; tick();
    ByteValid = 1'b0; FrameStart = 1'b1; tick();
    FrameStart = 1'b0; tick();
    run_frame(8'h32, 8'h80, pack(0, 0, 5, 0, 5), -1, "fs_discard");
    nv = 0;
    repeat (12) begin
      tick();
      if (TempValid) nv++;
    end
    check("fs_discard extra_valid", nv, 0);

    // FrameStart together with ByteValid in GOT_MSB restarts with the new byte as MSB.
    ByteValid = 1'b1; ReceivedData = 8'h19; tick();
    ByteValid = 1'b0; tick();
    FrameStart = 1'b1; ByteValid = 1'b1; ReceivedData = 8'h32; tick();
    FrameStart = 1'b0; ByteValid = 1'b0; tick();
    ByteValid = 1'b1; ReceivedData = 8'h80; tick();
    ByteValid = 1'b0;
    wait_valid(n);
    check("fs_with_byte latency", n, 8);
    check("fs_with_byte result", outputs_now(), pack(0, 0, 5, 0, 5));
    tick();
    last_exp = pack(0, 0, 5, 0, 5);

    // Stray byte three cycles into conversion, then one sampled on the final edge.
    run_frame(8'h19, 8'h00, pack(0, 0, 2, 5, 0), 2, "drop_mid");
    run_frame(8'hE7, 8'h00, pack(1, 0, 2, 5, 0), 7, "drop_last");
    run_frame(8'h32, 8'h80, pack(0, 0, 5, 0, 5), -1, "after_drop");

    // A new MSB is accepted in the cycle TempValid is high.
    ByteValid = 1'b1; ReceivedData = 8'h19; tick();
    ByteValid = 1'b0; tick();
    ByteValid = 1'b1; ReceivedData = 8'h00; tick();
    ByteValid = 1'b0;
    wait_valid(n);
    check("b2b first latency", n, 8);
    check("b2b first result", outputs_now(), pack(0, 0, 2, 5, 0));
    ByteValid = 1'b1; ReceivedData = 8'h80; tick();
    ByteValid = 1'b0;
    check("b2b no_drop", int'(ByteDropped), 0);
    tick();
    ByteValid = 1'b1; ReceivedData = 8'h00; tick();
    ByteValid = 1'b0;
    wait_valid(n);
    check("b2b second latency", n, 8);
    check("b2b second result", outputs_now(), pack(1, 1, 2, 8, 0));
    tick();
    last_exp = pack(1, 1, 2, 8, 0);

    // Reset in the fourth cycle of a conversion.
    ByteValid = 1'b1; ReceivedData = 8'h32; tick();
    ByteValid = 1'b0; tick();
    ByteValid = 1'b1; ReceivedData = 8'h80; tick();
    ByteValid = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("midreset outputs", outputs_now(), 0);
    check("midreset tempvalid", int'(TempValid), 0);
    check("midreset busy", int'(Busy), 0);
    check("midreset dropped", int'(ByteDropped), 0);
    tick();
    Reset = 1'b1;
    nv = 0;
    repeat (12) begin
      tick();
      if (TempValid) nv++;
    end
    check("midreset no_valid", nv, 0);
    last_exp = 0;
    run_frame(8'h19, 8'h00, pack(0, 0, 2, 5, 0), -1, "post_reset");

    // Random frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      m8 = 8'($urandom);
      l8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        FrameStart = 1'b1; tick();
        FrameStart = 1'b0;
      end
      drop_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      exp = model(m8, l8);
      run_frame(m8, l8, exp, drop_at, $sformatf("rand%0d %02h%02h", i, m8, l8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
